// File: rtl/clock_div_gen_if.sv
// clock_div_gen_if: configuration write channel (valid/ready) for clock_div_gen
interface clock_div_gen_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 8
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic cfg_valid;
  logic cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  modport master (output cfg_valid, cfg_ch, cfg_period, cfg_high, input cfg_ready);
  modport slave (input cfg_valid, cfg_ch, cfg_period, cfg_high, output cfg_ready);
endinterface

// File: rtl/clock_div_gen.sv
// clock_div_gen: NUM_CH programmable divided clocks with end-of-period ticks and a shared sync.
// Define CLOCK_DIV_GEN_GLITCHFREE_LOAD_EN to defer configuration loads to period boundaries.
module clock_div_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 8,
  parameter int DEF_PERIOD = 1,
  parameter int DEF_HIGH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync,
  clock_div_gen_if.slave cfg,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic en_q, ready_q, hit, ld_go;
  logic [CH_W-1:0] ld_ch;
  logic [CNT_W-1:0] ld_p, ld_h;
  logic [NUM_CH-1:0] wrap;
  assign cfg.cfg_ready = ready_q;
  // Out-of-range channel writes are handshaken but never reach a channel.
  assign hit = cfg.cfg_valid && ready_q && (32'(cfg.cfg_ch) < NUM_CH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) en_q <= 1'b0;
    else en_q <= en;
`ifdef CLOCK_DIV_GEN_GLITCHFREE_LOAD_EN
  logic pend;
  logic [CH_W-1:0] sh_ch;
  logic [CNT_W-1:0] sh_p, sh_h;
  // A parked write lands only where its channel's period ends, or while idle / realigning.
  assign ld_go = pend && (!en_q || sync || wrap[sh_ch]);
  assign ld_ch = sh_ch;
  assign ld_p = sh_p;
  assign ld_h = sh_h;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= 1'b0;
      ready_q <= 1'b0;
      sh_ch <= '0;
      sh_p <= '0;
      sh_h <= '0;
    end else begin
      pend <= ld_go ? 1'b0 : hit ? 1'b1 : pend;
      ready_q <= ld_go || !(hit || pend);
      if (hit) begin
        sh_ch <= cfg.cfg_ch;
        sh_p <= cfg.cfg_period;
        sh_h <= cfg.cfg_high;
      end
    end
`else
  assign ld_go = hit;
  assign ld_ch = cfg.cfg_ch;
  assign ld_p = cfg.cfg_period;
  assign ld_h = cfg.cfg_high;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ready_q <= 1'b0;
    else ready_q <= 1'b1;
`endif
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ld, clk_q, tick_q;
    logic [CNT_W-1:0] cnt, per, hi, cnt_d, per_d, hi_d;
    assign wrap[g] = cnt >= per;
    assign clk_o[g] = clk_q;
    assign tick_o[g] = tick_q;
    // Outputs are computed from next-state values so they line up with cnt in the same cycle.
    always_comb begin
      ld = ld_go && (ld_ch == CH_W'(g));
      per_d = ld ? ld_p : per;
      hi_d = ld ? ld_h : hi;
      cnt_d = (!en || !en_q || sync || ld || wrap[g]) ? '0 : cnt + CNT_W'(1);
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        per <= CNT_W'(DEF_PERIOD);
        hi <= CNT_W'(DEF_HIGH);
        clk_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt <= cnt_d;
        per <= per_d;
        hi <= hi_d;
        clk_q <= en && (cnt_d < hi_d);
        tick_q <= en && (cnt_d == per_d);
      end
  end
endmodule

// File: tb/tb_clock_div_gen.sv
// tb_clock_div_gen: vector table, directed corner sequences and a randomized run against a cycle model.
`timescale 1ns/1ps
module tb_clock_div_gen;
  localparam int NUM_CH = 3, CNT_W = 8, DEF_P = 1, DEF_H = 1;
`ifdef CLOCK_DIV_GEN_GLITCHFREE_LOAD_EN
  localparam bit GF = 1'b1;
`else
  localparam bit GF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sync = 1'b0;
  logic [NUM_CH-1:0] clk_o, tick_o;
  clock_div_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cif ();
  clock_div_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_P), .DEF_HIGH(DEF_H)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .cfg(cif), .clk_o(clk_o), .tick_o(tick_o)
  );
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int m_pos[NUM_CH], m_p[NUM_CH], m_h[NUM_CH];
  bit m_enq, m_ready, m_pend;
  int m_sch = 0, m_sp = 0, m_sh = 0;

  typedef struct {
    bit en;
    bit sync;
    logic [1:0] c;
    logic [1:0] t;
  } vec_t;
  vec_t tbl[24];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pos[c]) begin
      m_pos[c] = 0;
      m_p[c] = DEF_P;
      m_h[c] = DEF_H;
    end
    m_enq = 0;
    m_ready = 0;
    m_pend = 0;
  endtask

  // Position within the period advances modulo P+1; writes follow the selected load policy.
  task automatic model_step();
    bit acc, apply;
    int ch;
    ch = int'(cif.cfg_ch);
    acc = cif.cfg_valid && m_ready;
    apply = GF && m_pend && (!m_enq || sync || m_pos[m_sch] == m_p[m_sch]);
    foreach (m_pos[c]) m_pos[c] = (!en || !m_enq || sync) ? 0 : (m_pos[c] + 1) % (m_p[c] + 1);
    if (apply) begin
      m_p[m_sch] = m_sp;
      m_h[m_sch] = m_sh;
      m_pend = 0;
    end else if (acc && ch < NUM_CH) begin
      if (GF) begin
        m_pend = 1;
        m_sch = ch;
        m_sp = int'(cif.cfg_period);
        m_sh = int'(cif.cfg_high);
      end else begin
        m_p[ch] = int'(cif.cfg_period);
        m_h[ch] = int'(cif.cfg_high);
        m_pos[ch] = 0;
      end
    end
    m_enq = en;
    m_ready = !m_pend;
  endtask

  task automatic step();
    logic [NUM_CH-1:0] ec, et;
    model_step();
    @(posedge clk);
    #1;
    foreach (m_pos[c]) begin
      ec[c] = m_enq && (m_pos[c] < m_h[c]);
      et[c] = m_enq && (m_pos[c] == m_p[c]);
    end
    chk("model_clk_o", 32'(clk_o), 32'(ec));
    chk("model_tick_o", 32'(tick_o), 32'(et));
    chk("model_cfg_ready", 32'(cif.cfg_ready), 32'(m_ready));
  endtask

  task automatic cfg_write(int ch, int p, int h);
    int k;
    k = 0;
    while (!cif.cfg_ready && k < 20) begin
      step();
      k++;
    end
    chk("cfg_ready_wait", 32'(cif.cfg_ready), 32'd1);
    cif.cfg_valid = 1'b1;
    cif.cfg_ch = 2'(ch);
    cif.cfg_period = 8'(p);
    cif.cfg_high = 8'(h);
    step();
    cif.cfg_valid = 1'b0;
  endtask

  task automatic measure(string name);
    int cyc, hi;
    cyc = 1;
    hi = int'(clk_o[0]);
    while (!tick_o[0] && cyc < 40) begin
      step();
      cyc++;
      hi += int'(clk_o[0]);
    end
    chk({name, "_period"}, 32'(cyc), 32'd8);
    chk({name, "_high"}, 32'(hi), 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k, ticks;
    tbl = '{
      '{1, 0, 2'b01, 2'b00}, '{1, 0, 2'b01, 2'b00}, '{1, 0, 2'b00, 2'b00}, '{1, 0, 2'b00, 2'b01},
      '{1, 0, 2'b01, 2'b10}, '{1, 0, 2'b01, 2'b00}, '{1, 0, 2'b00, 2'b00}, '{1, 0, 2'b00, 2'b01},
      '{1, 0, 2'b01, 2'b00}, '{1, 0, 2'b01, 2'b10}, '{1, 0, 2'b00, 2'b00}, '{1, 1, 2'b01, 2'b00},
      '{1, 0, 2'b01, 2'b00}, '{1, 0, 2'b00, 2'b00}, '{1, 0, 2'b00, 2'b01}, '{1, 0, 2'b01, 2'b10},
      '{1, 0, 2'b01, 2'b00}, '{1, 0, 2'b00, 2'b00}, '{1, 0, 2'b00, 2'b01}, '{1, 1, 2'b01, 2'b00},
      '{1, 0, 2'b01, 2'b00}, '{0, 0, 2'b00, 2'b00}, '{0, 0, 2'b00, 2'b00}, '{1, 0, 2'b01, 2'b00}
    };
    cif.cfg_valid = 1'b0;
    cif.cfg_ch = '0;
    cif.cfg_period = '0;
    cif.cfg_high = '0;
    model_reset();
    #1;
    chk("reset_ready", 32'(cif.cfg_ready), 32'd0);
    chk("reset_clk_o", 32'(clk_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", 32'(cif.cfg_ready), 32'd1);
    cfg_write(0, 3, 2);
    cfg_write(1, 4, 0);
    step();
    step();
    for (int i = 0; i < 24; i++) begin
      en = tbl[i].en;
      sync = tbl[i].sync;
      step();
      chk($sformatf("vec%0d_clk", i), 32'(clk_o[1:0]), 32'(tbl[i].c));
      chk($sformatf("vec%0d_tick", i), 32'(tick_o[1:0]), 32'(tbl[i].t));
    end
    sync = 1'b0;
    cfg_write(1, 4, 9);
    repeat (6) step();
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("h_gt_p_clk1", 32'(clk_o[1]), 32'd1);
      ticks += int'(tick_o[1]);
    end
    chk("h_gt_p_ticks", 32'(ticks), 32'd2);
    k = 0;
    while (m_pos[0] != 1 && k < 10) begin
      step();
      k++;
    end
    if (k == 10) begin
      n_cmp++;
      n_bad++;
      $display("FAIL align_timeout: ch0 never reached cnt=1");
    end
    cif.cfg_valid = 1'b1;
    cif.cfg_ch = 2'd0;
    cif.cfg_period = 8'd7;
    cif.cfg_high = 8'd2;
    step();
    cif.cfg_valid = 1'b0;
`ifdef CLOCK_DIV_GEN_GLITCHFREE_LOAD_EN
    chk("gf_ready_pend1", 32'(cif.cfg_ready), 32'd0);
    step();
    chk("gf_ready_pend2", 32'(cif.cfg_ready), 32'd0);
    chk("gf_old_tick", 32'(tick_o[0]), 32'd1);
    step();
`endif
    chk("load_ready", 32'(cif.cfg_ready), 32'd1);
    chk("load_restart_clk0", 32'(clk_o[0]), 32'd1);
    measure("load");
    cif.cfg_valid = 1'b1;
    cif.cfg_ch = 2'd3;
    cif.cfg_period = 8'd1;
    cif.cfg_high = 8'd0;
    step();
    cif.cfg_valid = 1'b0;
    chk("oor_ready", 32'(cif.cfg_ready), 32'd1);
    chk("oor_ch1_clk", 32'(clk_o[1]), 32'd1);
    measure("oor");
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 19) != 0;
      sync = $urandom_range(0, 19) == 0;
      cif.cfg_valid = $urandom_range(0, 4) == 0;
      cif.cfg_ch = 2'($urandom_range(0, 3));
      cif.cfg_period = 8'($urandom_range(0, 9));
      cif.cfg_high = 8'($urandom_range(0, 11));
      step();
    end
    en = 1'b1;
    sync = 1'b0;
    cif.cfg_valid = 1'b0;
    cfg_write(0, 5, 3);
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clk_o", 32'(clk_o), 32'd0);
    chk("mid_rst_tick_o", 32'(tick_o), 32'd0);
    chk("mid_rst_ready", 32'(cif.cfg_ready), 32'd0);
    model_reset();
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("in_rst_clk_o", 32'(clk_o), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    step();
    chk("post_rst_clk", 32'(clk_o), 32'b111);
    chk("post_rst_tick", 32'(tick_o), 32'd0);
    step();
    chk("post_rst_clk2", 32'(clk_o), 32'd0);
    chk("post_rst_tick2", 32'(tick_o), 32'b111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_div_gen.md
CLOCK_DIV_GEN -- requirements
Module: clock_div_gen

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent divided-clock channels (1..8).
REQ-002 Parameter CNT_W, default 8, width of each channel's counter, period and high-time registers.
REQ-003 Parameter DEF_PERIOD, default 1, reset value of every channel's period register P.
REQ-004 Parameter DEF_HIGH, default 1, reset value of every channel's high-time register H.
REQ-005 clk  input  1  single system clock; all logic on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  global run enable.
REQ-008 sync  input  1  single-cycle pulse; realigns all channel counters to 0.
REQ-009 cfg_valid  input  1  configuration write request.
REQ-010 cfg_ready  output  1  configuration write can be accepted.
REQ-011 cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel index.
REQ-012 cfg_period  input  CNT_W  new P; output period is P+1 cycles.
REQ-013 cfg_high  input  CNT_W  new H; clk_o high for H cycles per period.
REQ-014 clk_o  output  NUM_CH  registered divided-clock waveforms.
REQ-015 tick_o  output  NUM_CH  registered one-cycle pulse on the last cycle of each period.

Function
REQ-016 Each channel SHALL hold counter cnt counting 0..P and wrapping to 0 on the cycle after cnt==P.
REQ-017 In any cycle with en_q=1, clk_o[i] SHALL equal (cnt_i < H_i) and tick_o[i] SHALL equal (cnt_i == P_i), with both outputs and cnt driven from flops in that same cycle.
REQ-018 Boundary: H=0 gives clk_o constant 0; H>P gives constant 1; P=0 gives tick_o constant 1 while running.
REQ-019 en_q is en registered; while en_q=0, all cnt SHALL be held at 0 and all clk_o/tick_o SHALL be 0; the first running cycle SHALL have cnt=0 on every channel.
REQ-020 sync=1 with en=1 SHALL force every cnt to 0 in the next cycle; a sync coinciding with cnt==P SHALL suppress the wrap (no extra period) but still show tick in the current cycle.
REQ-021 A configuration write SHALL be accepted on a clock edge where cfg_valid && cfg_ready.
REQ-022 A cfg_ch value >= NUM_CH SHALL be accepted and discarded.
REQ-023 A channel's new P/H SHALL take effect per REQ-030/031; other channels SHALL be unaffected.
REQ-024 Counter arithmetic SHALL be unsigned CNT_W-bit; a P decrease below the current cnt (immediate-load mode only) SHALL reset that cnt to 0.

Reset
REQ-025 Asserting rst_n=0 SHALL asynchronously clear all cnt, en_q, clk_o, tick_o and pending state to 0.
REQ-026 During reset, P SHALL be DEF_PERIOD, H SHALL be DEF_HIGH, and cfg_ready SHALL be 0.
REQ-027 cfg_ready SHALL become valid on the first clock edge after rst_n deasserts.
REQ-028 Reset asserted mid-period SHALL abandon the period with no completing tick.

Configuration
REQ-029 Macro CLOCK_DIV_GEN_GLITCHFREE_LOAD_EN selects the configuration load policy.
REQ-030 Defined: an accepted write SHALL go to a single shadow slot, with cfg_ready=0 while pending; it SHALL be applied on the edge where the target channel wraps (cnt==P), when en_q=0, or on sync. cfg_ready SHALL return to 1 the cycle after application, so no truncated or stretched clk_o pulse ever appears.
REQ-031 Undefined: cfg_ready SHALL be constant 1 after reset; P/H SHALL update on the accepting edge and that channel's cnt SHALL reset to 0.

Verification
REQ-032 NUM_CH=2, CNT_W=8, P0=3, H0=2, en=1 -> clk_o[0]=1,1,0,0 repeating; tick_o[0] on every 4th cycle (cnt=3).
REQ-033 P1=4, H1=0 and H1=9 -> clk_o[1] constant 0, then constant 1; tick_o[1] every 5 cycles in both cases.
REQ-034 Both channels running, sync pulse at ch0 cnt=2 -> next cycle cnt0=cnt1=0; ch0 period then restarts with clk_o[0]=1.
REQ-035 Macro defined, write P0=7 at cnt0=1 -> cfg_ready=0 until the cnt0=3 wrap; the following period is 8 cycles; no short pulse.
REQ-036 Macro undefined, same write -> cnt0=0 next cycle, period 8; cfg_ready stays 1; cfg_ch=3 write leaves all channels unchanged.
REQ-037 rst_n low mid-period -> clk_o=tick_o=0 immediately; after release P=DEF_PERIOD, H=DEF_HIGH, counting restarts at 0 once en_q=1.
